demux_deserializer_6: RTL
=========================

Name: demux_deserializer_6

Overview:
- Receive end of a 6-bit serial link. The transmit side walks a 6:1 selector across a word, one bit per beat; this block distributes each beat back to its slot with a 1:6 demux driven by an internal index counter.
- Presents the reassembled 6-bit word with a one-cycle valid strobe.
- Sits between the serial link pins and the parallel consumer in the workshop datapath.
- Every decode of the index, and every state decode, carries an explicit default, so synthesis infers no latches.

Parameters:
- N, 6, word width; fixed at 6 for this block, kept only for readability of the width checks.
- IDX_W, 3, width of the slot index.
- TIMEOUT, 0, idle cycles tolerated between beats while receiving; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse that begins reception of a word; sampled only in IDLE.
- din  input  1  serial data bit.
- din_valid  input  1  din carries a valid beat this cycle.
- data_out  output  6  last completed word; slot k holds beat k (LSB first).
- data_valid  output  1  one-cycle strobe when data_out is updated.
- busy  output  1  high in RECV and DONE.
- idx  output  3  current slot index (debug/visibility).
- timeout_err  output  1  one-cycle strobe when reception is aborted by timeout.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - All state updates on the rising edge of clk.
  - rst is synchronous and active-high.
  - While rst=1 at an edge: state=IDLE, idx=0, slot register=0, data_out=0, data_valid=0, busy=0, timeout_err=0, timeout counter=0.
- FSM states: IDLE, RECV, DONE (plus PAR under DEMUX_PARITY_EN).
- IDLE:
  - busy=0.
  - start=1 -> RECV, idx=0, slot register cleared, timeout counter cleared.
  - din/din_valid are ignored in IDLE.
- RECV:
  - busy=1.
  - On din_valid=1: slot[idx] <= din (the 1:6 demux).
    - If idx=5: -> DONE, idx holds 5.
    - Otherwise idx <= idx+1.
  - start in RECV is ignored; no restart.
  - Slots not addressed keep their value.
- DONE, for exactly one cycle:
  - data_out <= slot register; data_valid=1 in the cycle after the edge that accepted beat 5.
  - Then -> IDLE, idx=0.
  - Latency: 1 cycle from the 6th accepted beat to data_valid.
  - start asserted while in DONE is ignored.
- Index decode:
  - idx values 6 and 7 are unreachable.
  - Default case: no slot is written; FSM -> IDLE, idx=0.
- Output hold:
  - data_out holds its value until the next completed word.
  - data_valid is never high for two consecutive cycles.
- Timeout (TIMEOUT>0):
  - Counter increments each RECV cycle with din_valid=0; clears on din_valid=1.
  - When the counter reaches TIMEOUT: -> IDLE, timeout_err=1 for one cycle, data_out unchanged, idx=0.
- Simultaneous events:
  - rst overrides everything.
  - A beat arriving on the same cycle the timeout fires is dropped; the timeout wins.
- Reset mid-word: partial slots are discarded; no data_valid.

Optional Feature:
- Macro DEMUX_PARITY_EN.
- When defined:
  - After beat 5 the FSM enters PAR and waits for a 7th beat (din_valid=1) carrying even parity over the 6 data bits.
  - Output parity_err (1 bit, reset 0) is asserted together with data_valid when the XOR of the 6 data bits and the parity bit is 1.
  - data_out is still updated.
  - The timeout also applies in PAR.
- When undefined: no PAR state, no parity_err port; the word completes after 6 beats.

Test Plan:
- Reset then start; beats 1,0,1,1,0,0 on consecutive cycles -> data_valid=1 exactly one cycle after the last beat; data_out=6'b001101; busy falls with return to IDLE.
- Same word with din_valid=0 gaps of 2 cycles between beats (TIMEOUT=0) -> data_out=6'b001101; idx steps 0..5 only on valid beats.
- start pulsed again mid-word after beat 2, then beats 0,1,1 -> ignored restart; data_out reflects all 6 beats of the original word; a single data_valid.
- TIMEOUT=4, 3 beats then 4 idle cycles -> timeout_err pulses once; data_out keeps its previous value 6'b001101; next start + 6 beats of 1 -> data_out=6'b111111.
- rst asserted after beat 3 -> next cycle idx=0, data_out=0, busy=0, no data_valid.
- DEMUX_PARITY_EN: word 6'b001101 + parity 1 -> parity_err=0; same word + parity 0 -> parity_err=1 with data_valid.

Source files
------------

// File: rtl/demux_deserializer_6.sv
// demux_deserializer_6: receive end of a 6-bit serial link.
//
// An index counter drives a 1:6 demux that drops each valid serial beat into
// its slot (LSB first). When the sixth beat is accepted, the reassembled word
// is published on data_out with a one-cycle data_valid strobe. An optional
// idle timeout aborts a stalled reception.
//
// Optional feature: define DEMUX_PARITY_EN to expect a seventh even-parity
// beat after the data bits and report a mismatch on parity_err.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   start        pulse that begins reception; only honoured in IDLE
//   din          serial data bit
//   din_valid    din carries a valid beat this cycle
//   data_out     last completed word (slot k = beat k)
//   data_valid   one-cycle strobe when data_out is updated
//   busy         high while a word is in flight (RECV/PAR/DONE)
//   idx          current slot index
//   timeout_err  one-cycle strobe when reception is aborted by timeout
//   parity_err   (DEMUX_PARITY_EN only) parity mismatch, with data_valid
module demux_deserializer_6 #(
  parameter int unsigned N       = 6,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
  output logic [N-1:0]     data_out,
  output logic             data_valid,
  output logic             busy,
  output logic [IDX_W-1:0] idx,
  output logic             timeout_err
`ifdef DEMUX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRecv = 2'd1;
  localparam logic [1:0] StDone = 2'd2;
`ifdef DEMUX_PARITY_EN
  localparam logic [1:0] StPar  = 2'd3;
`endif

  // Counter is kept at least one bit wide so the TIMEOUT=0 build stays legal.
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     slot_q, slot_d;
  logic [N-1:0]     data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_fire;
`ifdef DEMUX_PARITY_EN
  logic             parity_err_q, parity_err_d;
`endif

  assign cnt_inc = cnt_q + 1'b1;
  // Fires on the idle cycle that brings the counter up to TIMEOUT; a valid
  // beat always clears the counter, so a beat can never be lost to it.
  assign timeout_fire = (TIMEOUT != 0) && !din_valid && (cnt_inc == TO_VAL);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    slot_d        = slot_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    timeout_err_d = 1'b0;
    cnt_d         = cnt_q;
`ifdef DEMUX_PARITY_EN
    parity_err_d  = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        idx_d = '0;
        if (start) begin
          state_d = StRecv;
          slot_d  = '0;
          cnt_d   = '0;
        end
      end

      StRecv: begin
        if (timeout_fire) begin
          state_d       = StIdle;
          idx_d         = '0;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end else if (din_valid) begin
          cnt_d = '0;
          // 1:6 demux: only the addressed slot is written.
          case (idx_q)
            3'd0: begin slot_d[0] = din; idx_d = 3'd1; end
            3'd1: begin slot_d[1] = din; idx_d = 3'd2; end
            3'd2: begin slot_d[2] = din; idx_d = 3'd3; end
            3'd3: begin slot_d[3] = din; idx_d = 3'd4; end
            3'd4: begin slot_d[4] = din; idx_d = 3'd5; end
            3'd5: begin
              slot_d[5] = din;
`ifdef DEMUX_PARITY_EN
              state_d = StPar;
`else
              // Publish on the accepting edge so data_out is already valid in
              // the DONE cycle alongside the strobe.
              state_d      = StDone;
              data_out_d   = {din, slot_q[N-2:0]};
              data_valid_d = 1'b1;
`endif
            end
            default: begin
              state_d = StIdle;
              idx_d   = '0;
            end
          endcase
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_inc;
        end
      end

`ifdef DEMUX_PARITY_EN
      StPar: begin
        if (timeout_fire) begin
          state_d       = StIdle;
          idx_d         = '0;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end else if (din_valid) begin
          cnt_d        = '0;
          state_d      = StDone;
          data_out_d   = slot_q;
          data_valid_d = 1'b1;
          // Even parity: data bits plus parity bit must XOR to zero.
          parity_err_d = ^{slot_q, din};
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_inc;
        end
      end
`endif

      StDone: begin
        state_d = StIdle;
        idx_d   = '0;
      end

      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      slot_q        <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
`ifdef DEMUX_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      slot_q        <= slot_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
`ifdef DEMUX_PARITY_EN
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign busy        = (state_q != StIdle);
  assign idx         = idx_q;
  assign timeout_err = timeout_err_q;
`ifdef DEMUX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule
